// File: rtl/gcbp_pkg.sv
// Shared constants and helpers for the Gray-code bit-plane capture block.
package gcbp_pkg;

    localparam int WIN_SIZE  = 128;
    localparam int WIN_BITS  = 7;
    localparam int COL_W     = 11;
    localparam int BRAM_LANES = 16;

    localparam logic [1:0] SLOT_NEXT_RST = 2'd0;
    localparam logic [1:0] SLOT_CURR_RST = 2'd1;
    localparam logic [1:0] SLOT_PREV_RST = 2'd2;

    typedef struct packed {
        logic [8:0]            addr;
        logic [WIN_SIZE-1:0]   data;
        logic [BRAM_LANES-1:0] en;
    } bram_wr_t;

    function automatic logic [7:0] gray8(input logic [7:0] l);
        return l ^ (l >> 1);
    endfunction

endpackage

// File: rtl/gcbp_slot_rotator.sv
// Three-slot frame buffer rotation: the slot being written becomes current,
// current becomes previous, and the oldest slot is recycled for writing.
module gcbp_slot_rotator
    import gcbp_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_resetn,
    input  logic       i_rotate,
    output logic [1:0] o_next,
    output logic [1:0] o_curr,
    output logic [1:0] o_prev
);

    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            o_next <= SLOT_NEXT_RST;
            o_curr <= SLOT_CURR_RST;
            o_prev <= SLOT_PREV_RST;
        end else if (i_rotate) begin
            o_prev <= o_curr;
            o_curr <= o_next;
            o_next <= o_prev;
        end
    end

endmodule

// File: rtl/gcbp.sv
// Captures one Gray-code bit plane of a 128x128 luma window and emits one
// 128-bit BRAM row write per fully captured window line.
module gcbp
    import gcbp_pkg::*;
#(
    parameter int ROW_START = 0,
    parameter int COL_START = 0,
    parameter int PLANE_BIT = 4
) (
    input  logic         i_clk,
    input  logic         i_resetn,
    input  logic [8:0]   i_luma_data,
    input  logic         i_new_line,
    input  logic         i_luma_data_valid,
    input  logic [8:0]   i_line_cnt,
    input  logic         i_new_frame,
    output logic [8:0]   o_bram_array_write_addr,
    output logic [127:0] o_bram_array_write_data,
    output logic [15:0]  o_bram_array_write_enable,
    output logic [1:0]   o_next_frame_loc,
    output logic [1:0]   o_curr_frame_loc,
    output logic [1:0]   o_prev_frame_loc
);

    localparam logic [11:0] COL_LO   = 12'(COL_START);
    localparam logic [11:0] COL_HI   = 12'(COL_START + WIN_SIZE);
    localparam logic [9:0]  ROW_LO   = 10'(ROW_START);
    localparam logic [9:0]  ROW_HI   = 10'(ROW_START + WIN_SIZE);
    localparam logic [8:0]  ROW_BASE = 9'(ROW_START);

    logic                  line_active;
    logic [COL_W-1:0]      col;
    logic [WIN_BITS-1:0]   cap_cnt;
    logic [WIN_SIZE-1:0]   shreg;
    bram_wr_t              wr;

    logic                  line_start;
    logic [COL_W-1:0]      col_eff;
    logic [COL_W-1:0]      col_inc;
    logic                  col_in_win;
    logic                  row_in_win;
    logic                  capture;
    logic                  last_pix;
    logic [7:0]            gray;
    logic                  pix;
    logic [WIN_BITS-1:0]   cnt_base;
    logic [WIN_SIZE-1:0]   shreg_base;
    logic [WIN_SIZE-1:0]   shreg_nxt;
    logic [WIN_BITS-1:0]   row_off;
    logic                  unused_luma_msb;

    assign unused_luma_msb = i_luma_data[8];

    // A valid sample coinciding with a line/frame start belongs to the new line as column 0.
    always_comb begin
        line_start = i_new_line | i_new_frame;
        col_eff    = line_start ? '0 : col;
        col_inc    = (col_eff == '1) ? col_eff : col_eff + 1'b1;
        col_in_win = ({1'b0, col_eff} >= COL_LO) && ({1'b0, col_eff} < COL_HI);
        row_in_win = ({1'b0, i_line_cnt} >= ROW_LO) && ({1'b0, i_line_cnt} < ROW_HI);
        capture    = i_luma_data_valid && (line_active || line_start) && col_in_win && row_in_win;
        gray       = gray8(i_luma_data[7:0]);
        pix        = gray[PLANE_BIT];
        cnt_base   = line_start ? '0 : cap_cnt;
        shreg_base = line_start ? '0 : shreg;
        shreg_nxt  = {shreg_base[WIN_SIZE-2:0], pix};
        last_pix   = capture && (cnt_base == '1);
        row_off    = WIN_BITS'(i_line_cnt - ROW_BASE);
    end

    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            line_active <= 1'b0;
            col         <= '0;
            cap_cnt     <= '0;
            shreg       <= '0;
            wr          <= '0;
        end else begin
            if (line_start)
                line_active <= 1'b1;

            if (i_luma_data_valid)
                col <= col_inc;
            else if (line_start)
                col <= '0;

            wr.en <= '0;
            if (capture) begin
                shreg   <= shreg_nxt;
                cap_cnt <= cnt_base + 1'b1;
                if (last_pix) begin
                    wr.addr <= {o_next_frame_loc, row_off};
                    wr.data <= shreg_nxt;
                    wr.en   <= '1;
                end
            end else if (line_start) begin
                // Discard any partial word from the previous line.
                shreg   <= '0;
                cap_cnt <= '0;
            end
        end
    end

    assign o_bram_array_write_addr   = wr.addr;
    assign o_bram_array_write_data   = wr.data;
    assign o_bram_array_write_enable = wr.en;

    gcbp_slot_rotator u_rot (
        .i_clk    (i_clk),
        .i_resetn (i_resetn),
        .i_rotate (i_new_frame),
        .o_next   (o_next_frame_loc),
        .o_curr   (o_curr_frame_loc),
        .o_prev   (o_prev_frame_loc)
    );

endmodule

// File: tb/tb_gcbp.sv
// Directed + randomized bench for gcbp with a line-level reference model.
module tb_gcbp;

    localparam int ROW_START = 0;
    localparam int COL_START = 0;
    localparam int PLANE_BIT = 4;

    logic         clk;
    logic         rst_n;
    logic [8:0]   luma;
    logic         new_line;
    logic         valid;
    logic [8:0]   line_cnt;
    logic         new_frame;
    logic [8:0]   wr_addr;
    logic [127:0] wr_data;
    logic [15:0]  wr_en;
    logic [1:0]   next_loc, curr_loc, prev_loc;

    int checks   = 0;
    int failures = 0;
    int bad_en   = 0;

    logic [136:0] wq[$];
    int m_next, m_curr, m_prev;

    gcbp #(.ROW_START(ROW_START), .COL_START(COL_START), .PLANE_BIT(PLANE_BIT)) dut (
        .i_clk                     (clk),
        .i_resetn                  (rst_n),
        .i_luma_data               (luma),
        .i_new_line                (new_line),
        .i_luma_data_valid         (valid),
        .i_line_cnt                (line_cnt),
        .i_new_frame               (new_frame),
        .o_bram_array_write_addr   (wr_addr),
        .o_bram_array_write_data   (wr_data),
        .o_bram_array_write_enable (wr_en),
        .o_next_frame_loc          (next_loc),
        .o_curr_frame_loc          (curr_loc),
        .o_prev_frame_loc          (prev_loc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst_n) begin
            if (wr_en == 16'hFFFF) wq.push_back({wr_addr, wr_data});
            else if (wr_en != 16'h0000) bad_en++;
        end
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit plane_bit(input logic [7:0] l);
        int g;
        g = int'(l) ^ (int'(l) / 2);
        return bit'((g >> PLANE_BIT) & 1);
    endfunction

    task automatic chk_slots(input string tag);
        chk({tag, " next"}, 128'(next_loc), 128'(m_next));
        chk({tag, " curr"}, 128'(curr_loc), 128'(m_curr));
        chk({tag, " prev"}, 128'(prev_loc), 128'(m_prev));
    endtask

    task automatic idle();
        new_line = 0; new_frame = 0; valid = 0;
    endtask

    // mode 0: constant lv, 1: alternate 0x10/0x00, 2: random luma
    task automatic run_line(input string tag, input int line, input int nvalid,
                            input bit nf, input int mode, input logic [7:0] lv);
        logic [7:0]   px[$];
        logic [127:0] exp_d;
        int           idx, tmp;
        bit           exp_wr;
        for (int i = 0; i < nvalid; i++)
            px.push_back(mode == 0 ? lv : mode == 1 ? ((i % 2 == 0) ? 8'h10 : 8'h00) : 8'($urandom));
        if (nf) begin
            tmp = m_next; m_next = m_prev; m_prev = m_curr; m_curr = tmp;
        end
        @(posedge clk); #1;
        new_line = 1; new_frame = nf; line_cnt = 9'(line); idx = 0; valid = 0;
        if (nvalid > 0 && $urandom_range(0, 1) == 1) begin
            valid = 1; luma = {1'($urandom), px[0]}; idx = 1;
        end
        while (idx < nvalid) begin
            @(posedge clk); #1;
            new_line = 0; new_frame = 0;
            if ($urandom_range(0, 3) == 0) valid = 0;
            else begin
                valid = 1; luma = {1'($urandom), px[idx]}; idx++;
            end
        end
        @(posedge clk); #1; idle();
        repeat (3) @(posedge clk);
        #1;
        exp_wr = (line >= ROW_START) && (line < ROW_START + 128) && (nvalid >= COL_START + 128);
        exp_d = '0;
        for (int k = 0; k < 128; k++)
            if (exp_wr) exp_d[127 - k] = plane_bit(px[COL_START + k]);
        chk({tag, " writes"}, 128'(wq.size()), 128'(exp_wr));
        if (exp_wr && wq.size() == 1) begin
            chk({tag, " addr"}, 128'(wq[0][136:128]), 128'({2'(m_next), 7'(line - ROW_START)}));
            chk({tag, " data"}, wq[0][127:0], exp_d);
        end
        wq.delete();
    endtask

    initial begin
        rst_n = 0; luma = 0; line_cnt = 0; idle();
        m_next = 0; m_curr = 1; m_prev = 2;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst en", 128'(wr_en), 128'h0);
        chk("rst addr", 128'(wr_addr), 128'h0);
        chk("rst data", wr_data, 128'h0);
        chk_slots("rst");
        @(posedge clk); #1; rst_n = 1;

        // Directed plane patterns; first line of a frame rotates the slots.
        run_line("l0 0x10", 0, 128, 1, 0, 8'h10);
        chk_slots("frame1");
        run_line("0x08", 1, 128, 0, 0, 8'h08);
        run_line("0x18", 2, 128, 0, 0, 8'h18);
        run_line("0x30", 3, 128, 0, 0, 8'h30);
        run_line("alt", 4, 128, 0, 1, 8'h00);

        // Frame rotation through a full period, with writes tracking next.
        run_line("f2 l5", 5, 128, 1, 2, 8'h00);
        chk_slots("frame2");
        run_line("f3 l5", 5, 128, 1, 2, 8'h00);
        chk_slots("frame3");
        run_line("f4 l5", 5, 128, 1, 2, 8'h00);
        chk_slots("frame4");

        // Boundaries: short line, out-of-window row, overlong line, last window row.
        run_line("short", 6, 100, 0, 2, 8'h00);
        run_line("row130", 130, 128, 0, 2, 8'h00);
        run_line("long", 8, 200, 0, 2, 8'h00);
        run_line("row127", 127, 127, 0, 2, 8'h00);
        run_line("row127b", 127, 128, 0, 2, 8'h00);
        for (int n = 0; n < 4; n++)
            run_line("rand", 9 + n, 128 + int'($urandom_range(0, 40)), 0, 2, 8'h00);

        // Reset in the middle of a line abandons the partial word.
        @(posedge clk); #1;
        new_line = 1; line_cnt = 9'd20; valid = 1; luma = 9'h010;
        for (int i = 0; i < 60; i++) begin
            @(posedge clk); #1; new_line = 0;
        end
        rst_n = 0; idle();
        m_next = 0; m_curr = 1; m_prev = 2;
        @(negedge clk);
        chk("midrst en", 128'(wr_en), 128'h0);
        chk_slots("midrst");
        @(posedge clk); #1; rst_n = 1;
        valid = 1;
        for (int i = 0; i < 150; i++) @(posedge clk);
        #1; idle();
        repeat (3) @(posedge clk);
        #1;
        chk("post-rst no line", 128'(wq.size()), 128'h0);
        wq.delete();
        run_line("post-rst full", 21, 128, 0, 2, 8'h00);

        chk("enable encoding", 128'(bad_en), 128'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
